// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and sequencing controller for the 5-stage MIPS pipeline.
// Combinational forwarding/stall terms plus a small FSM for multi-cycle loads and syscall drain/halt.
module pipeline_hazard_ctrl #(
    parameter int MEM_LAT   = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_rs_d,
    input  logic [4:0] i_rt_d,
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rt_e,
    input  logic [4:0] i_write_reg_e,
    input  logic [4:0] i_write_reg_m,
    input  logic [4:0] i_write_reg_w,
    input  logic       i_reg_write_e,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    input  logic       i_mem_to_reg_e,
    input  logic       i_mem_to_reg_m,
    input  logic       i_mem_read_m,
    input  logic       i_branch_d,
    input  logic       i_pc_src_d,
    input  logic       i_syscall_e,
    input  logic       i_resume,
    output logic       o_stall_f,
    output logic       o_stall_d,
    output logic       o_stall_e,
    output logic       o_stall_m,
    output logic       o_flush_d,
    output logic       o_flush_e,
    output logic [1:0] o_fwd_a_e,
    output logic [1:0] o_fwd_b_e,
    output logic       o_fwd_a_d,
    output logic       o_fwd_b_d,
    output logic       o_halted
);

    localparam int WAIT_INIT  = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
    localparam int DRAIN_INIT = (DRAIN_CYC > 1) ? DRAIN_CYC - 1 : 0;
    localparam int MAX_INIT   = (WAIT_INIT > DRAIN_INIT) ? WAIT_INIT : DRAIN_INIT;
    localparam int CNT_W      = (MAX_INIT < 1) ? 1 : $clog2(MAX_INIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]   w_drain_cnt_next;

    logic w_m_valid;
    logic w_w_valid;
    logic w_e_hits_d;
    logic w_m_hits_d;
    logic w_lw_stall;
    logic w_br_stall;
    logic w_hz;
    logic w_mem_issue;

    // Register zero is never a real producer, so it never forwards or stalls.
    assign w_m_valid = i_reg_write_m && (i_write_reg_m != 5'd0);
    assign w_w_valid = i_reg_write_w && (i_write_reg_w != 5'd0);

    always_comb begin
        o_fwd_a_e = 2'b00;
        if (w_m_valid && (i_write_reg_m == i_rs_e))
            o_fwd_a_e = 2'b10;
        else if (w_w_valid && (i_write_reg_w == i_rs_e))
            o_fwd_a_e = 2'b01;

        o_fwd_b_e = 2'b00;
        if (w_m_valid && (i_write_reg_m == i_rt_e))
            o_fwd_b_e = 2'b10;
        else if (w_w_valid && (i_write_reg_w == i_rt_e))
            o_fwd_b_e = 2'b01;
    end

    assign o_fwd_a_d = w_m_valid && (i_write_reg_m == i_rs_d);
    assign o_fwd_b_d = w_m_valid && (i_write_reg_m == i_rt_d);

    assign w_e_hits_d = (i_write_reg_e != 5'd0) &&
                        ((i_write_reg_e == i_rs_d) || (i_write_reg_e == i_rt_d));
    assign w_m_hits_d = (i_write_reg_m != 5'd0) &&
                        ((i_write_reg_m == i_rs_d) || (i_write_reg_m == i_rt_d));

    assign w_lw_stall  = i_mem_to_reg_e && w_e_hits_d;
    assign w_br_stall  = i_branch_d && ((i_reg_write_e && w_e_hits_d) ||
                                        (i_mem_to_reg_m && w_m_hits_d));
    assign w_hz        = w_lw_stall || w_br_stall;
    assign w_mem_issue = i_mem_read_m && (MEM_LAT > 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_drain_cnt_next = r_drain_cnt;
        o_stall_f        = 1'b0;
        o_stall_d        = 1'b0;
        o_stall_e        = 1'b0;
        o_stall_m        = 1'b0;
        o_flush_d        = 1'b0;
        o_flush_e        = 1'b0;
        o_halted         = 1'b0;

        case (r_state)
            RUN: begin
                // An outstanding load is older than the syscall, so it is served first.
                if (w_mem_issue) begin
                    o_stall_f       = 1'b1;
                    o_stall_d       = 1'b1;
                    o_stall_e       = 1'b1;
                    o_stall_m       = 1'b1;
                    w_state_next    = MEM_WAIT;
                    w_wait_cnt_next = CNT_W'(WAIT_INIT);
                end else if (i_syscall_e) begin
                    o_stall_f        = 1'b1;
                    o_stall_d        = 1'b1;
                    o_flush_e        = 1'b1;
                    w_state_next     = DRAIN;
                    w_drain_cnt_next = CNT_W'(DRAIN_INIT);
                end else begin
                    o_stall_f = w_hz;
                    o_stall_d = w_hz;
                    o_flush_e = w_hz;
                    o_flush_d = i_pc_src_d && !w_hz;
                end
            end
            MEM_WAIT: begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_stall_e = 1'b1;
                o_stall_m = 1'b1;
                if (r_wait_cnt == '0)
                    w_state_next = RUN;
                else
                    w_wait_cnt_next = r_wait_cnt - CNT_W'(1);
            end
            DRAIN: begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_flush_e = 1'b1;
                if (r_drain_cnt == '0)
                    w_state_next = HALT;
                else
                    w_drain_cnt_next = r_drain_cnt - CNT_W'(1);
            end
            HALT: begin
                o_halted  = 1'b1;
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_stall_e = 1'b1;
                o_stall_m = 1'b1;
                if (i_resume)
                    w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Two instances share stimulus: dut2 uses MEM_LAT=2, dut3 uses MEM_LAT=3; both DRAIN_CYC=2.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       rstN;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       memReadM, branchD, pcSrcD, syscallE, resume;

    logic       stallF2, stallD2, stallE2, stallM2, flushD2, flushE2, halted2;
    logic [1:0] fwdAE2, fwdBE2;
    logic       fwdAD2, fwdBD2;
    logic       stallF3, stallD3, stallE3, stallM3, flushD3, flushE3, halted3;
    logic [1:0] fwdAE3, fwdBE3;
    logic       fwdAD3, fwdBD3;

    logic [6:0] ctrl2, ctrl3;
    int         checkCount = 0;
    int         errorCount = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MEM_LAT(2), .DRAIN_CYC(2)) dut2 (
        .i_clk(clock), .i_rst_n(rstN),
        .i_rs_d(rsD), .i_rt_d(rtD), .i_rs_e(rsE), .i_rt_e(rtE),
        .i_write_reg_e(writeRegE), .i_write_reg_m(writeRegM), .i_write_reg_w(writeRegW),
        .i_reg_write_e(regWriteE), .i_reg_write_m(regWriteM), .i_reg_write_w(regWriteW),
        .i_mem_to_reg_e(memToRegE), .i_mem_to_reg_m(memToRegM), .i_mem_read_m(memReadM),
        .i_branch_d(branchD), .i_pc_src_d(pcSrcD), .i_syscall_e(syscallE), .i_resume(resume),
        .o_stall_f(stallF2), .o_stall_d(stallD2), .o_stall_e(stallE2), .o_stall_m(stallM2),
        .o_flush_d(flushD2), .o_flush_e(flushE2),
        .o_fwd_a_e(fwdAE2), .o_fwd_b_e(fwdBE2), .o_fwd_a_d(fwdAD2), .o_fwd_b_d(fwdBD2),
        .o_halted(halted2)
    );

    pipeline_hazard_ctrl #(.MEM_LAT(3), .DRAIN_CYC(2)) dut3 (
        .i_clk(clock), .i_rst_n(rstN),
        .i_rs_d(rsD), .i_rt_d(rtD), .i_rs_e(rsE), .i_rt_e(rtE),
        .i_write_reg_e(writeRegE), .i_write_reg_m(writeRegM), .i_write_reg_w(writeRegW),
        .i_reg_write_e(regWriteE), .i_reg_write_m(regWriteM), .i_reg_write_w(regWriteW),
        .i_mem_to_reg_e(memToRegE), .i_mem_to_reg_m(memToRegM), .i_mem_read_m(memReadM),
        .i_branch_d(branchD), .i_pc_src_d(pcSrcD), .i_syscall_e(syscallE), .i_resume(resume),
        .o_stall_f(stallF3), .o_stall_d(stallD3), .o_stall_e(stallE3), .o_stall_m(stallM3),
        .o_flush_d(flushD3), .o_flush_e(flushE3),
        .o_fwd_a_e(fwdAE3), .o_fwd_b_e(fwdBE3), .o_fwd_a_d(fwdAD3), .o_fwd_b_d(fwdBD3),
        .o_halted(halted3)
    );

    // Control vector layout: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, halted}
    assign ctrl2 = {stallF2, stallD2, stallE2, stallM2, flushD2, flushE2, halted2};
    assign ctrl3 = {stallF3, stallD3, stallE3, stallM3, flushD3, flushE3, halted3};

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeRegE = 0; writeRegM = 0; writeRegW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0;
        memToRegE = 0; memToRegM = 0; memReadM = 0;
        branchD = 0; pcSrcD = 0; syscallE = 0; resume = 0;
    endtask

    // Advance one clock; inputs are then changed well clear of the edge.
    task automatic applyStimulus();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rstN = 1'b0;
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("resetCtrl2", {1'b0, ctrl2}, 8'b0000_0000);
        checkOutput("resetCtrl3", {1'b0, ctrl3}, 8'b0000_0000);
        rstN = 1'b1;

        // Forwarding priority and register-zero suppression
        regWriteM = 1; writeRegM = 8; rsE = 8;
        regWriteW = 1; writeRegW = 8; rtE = 8; rsD = 8; rtD = 3;
        settle();
        checkOutput("fwdAE_m", {6'b0, fwdAE2}, 8'd2);
        checkOutput("fwdBE_w", {6'b0, fwdBE2}, 8'd2);
        checkOutput("fwdAD", {7'b0, fwdAD2}, 8'd1);
        checkOutput("fwdBD", {7'b0, fwdBD2}, 8'd0);
        writeRegM = 0; rsE = 0;
        settle();
        checkOutput("fwdAE_zero", {6'b0, fwdAE2}, 8'd0);
        checkOutput("fwdBE_wOnly", {6'b0, fwdBE2}, 8'd1);
        checkOutput("fwdAD_zero", {7'b0, fwdAD2}, 8'd0);
        writeRegM = 5; rsE = 5; rtE = 5; writeRegW = 5; rtD = 5;
        settle();
        checkOutput("fwdAE_prio", {6'b0, fwdAE2}, 8'd2);
        checkOutput("fwdBE_prio", {6'b0, fwdBE2}, 8'd2);
        checkOutput("fwdBD", {7'b0, fwdBD2}, 8'd1);
        regWriteM = 0;
        settle();
        checkOutput("fwdAE_noM", {6'b0, fwdAE2}, 8'd1);
        checkOutput("fwdBD_noM", {7'b0, fwdBD2}, 8'd0);
        clearInputs();

        // Load-use stall suppresses branch flush for one cycle
        memToRegE = 1; writeRegE = 9; rtD = 9; pcSrcD = 1;
        settle();
        checkOutput("lwStall", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        memToRegE = 0;
        settle();
        checkOutput("lwRelease", {1'b0, ctrl2}, 8'b0000_0100);
        memToRegE = 1; writeRegE = 0; rsD = 0; rtD = 0; pcSrcD = 0;
        settle();
        checkOutput("lwZeroReg", {1'b0, ctrl2}, 8'b0000_0000);
        clearInputs();
        branchD = 1; regWriteE = 1; writeRegE = 4; rsD = 4;
        settle();
        checkOutput("brStallE", {1'b0, ctrl2}, 8'b0110_0010);
        clearInputs();
        branchD = 1; memToRegM = 1; writeRegM = 7; rtD = 7;
        settle();
        checkOutput("brStallM", {1'b0, ctrl2}, 8'b0110_0010);
        branchD = 0;
        settle();
        checkOutput("noBranch", {1'b0, ctrl2}, 8'b0000_0000);
        clearInputs();

        // Multi-cycle load freeze: 3 cycles at MEM_LAT=3, 2 at MEM_LAT=2
        memReadM = 1;
        settle();
        checkOutput("memIssue3", {1'b0, ctrl3}, 8'b0111_1000);
        checkOutput("memIssue2", {1'b0, ctrl2}, 8'b0111_1000);
        applyStimulus();
        memReadM = 0;
        settle();
        checkOutput("memWaitA3", {1'b0, ctrl3}, 8'b0111_1000);
        checkOutput("memWait2", {1'b0, ctrl2}, 8'b0111_1000);
        applyStimulus();
        settle();
        checkOutput("memWaitB3", {1'b0, ctrl3}, 8'b0111_1000);
        checkOutput("memDone2", {1'b0, ctrl2}, 8'b0000_0000);
        applyStimulus();
        settle();
        checkOutput("memDone3", {1'b0, ctrl3}, 8'b0000_0000);

        // Syscall drain then halt, with a load ignored during drain
        syscallE = 1;
        settle();
        checkOutput("sysRun", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        syscallE = 0; memReadM = 1;
        settle();
        checkOutput("drain1", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        memReadM = 0;
        settle();
        checkOutput("drain2", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        settle();
        checkOutput("halt", {1'b0, ctrl2}, 8'b0111_1001);
        applyStimulus();
        settle();
        checkOutput("haltHold", {1'b0, ctrl2}, 8'b0111_1001);
        resume = 1;
        applyStimulus();
        resume = 0;
        settle();
        checkOutput("resumed", {1'b0, ctrl2}, 8'b0000_0000);

        // Load and syscall together: load first, then drain
        memReadM = 1; syscallE = 1;
        settle();
        checkOutput("bothIssue", {1'b0, ctrl2}, 8'b0111_1000);
        applyStimulus();
        memReadM = 0;
        settle();
        checkOutput("bothWait", {1'b0, ctrl2}, 8'b0111_1000);
        applyStimulus();
        settle();
        checkOutput("bothSysRun", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        syscallE = 0;
        settle();
        checkOutput("bothDrain1", {1'b0, ctrl2}, 8'b0110_0010);
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("bothHalt", {1'b0, ctrl2}, 8'b0111_1001);

        // Synchronous reset out of HALT
        rstN = 0;
        settle();
        checkOutput("rstHaltPre", {1'b0, ctrl2}, 8'b0111_1001);
        applyStimulus();
        settle();
        checkOutput("rstHalt", {1'b0, ctrl2}, 8'b0000_0000);
        checkOutput("rstHalt3", {1'b0, ctrl3}, 8'b0000_0000);
        rstN = 1;

        // Synchronous reset out of MEM_WAIT
        memReadM = 1;
        applyStimulus();
        memReadM = 0; rstN = 0;
        settle();
        checkOutput("rstWaitPre2", {1'b0, ctrl2}, 8'b0111_1000);
        checkOutput("rstWaitPre3", {1'b0, ctrl3}, 8'b0111_1000);
        applyStimulus();
        settle();
        checkOutput("rstWait2", {1'b0, ctrl2}, 8'b0000_0000);
        checkOutput("rstWait3", {1'b0, ctrl3}, 8'b0000_0000);
        rstN = 1;
        applyStimulus();
        settle();
        checkOutput("afterRst3", {1'b0, ctrl3}, 8'b0000_0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
